imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
//   Parametrised, pipelined immediate extender: widens an IN_W-bit field to OUT_W bits.
//   Modes: zero-extend, sign-extend, ones-fill, and sign-extend-then-shift-left.
//   Sits between instruction decode and the ALU operand mux.
//   Valid/ready on both sides; a 2-entry skid buffer sustains 1 transfer/cycle under backpressure.
// PARAMETERS
//   IN_W      7    input immediate width (1..OUT_W)
//   OUT_W     20   output width (IN_W..32)
//   SHIFT_AMT 1    left-shift applied in mode 2'b11 (0..OUT_W-1)
//   CNT_W     8    width of the transfer counter
// PORTS
//   clk        input   1      rising-edge clock, single clock domain
//   reset      input   1      synchronous, active-high reset
//   in_valid   input   1      in_imm/in_mode valid
//   in_ready   output  1      block can accept input this cycle
//   in_imm     input   IN_W   immediate field
//   in_mode    input   2      00 zero, 01 sign, 10 ones-fill, 11 sign+shl
//   out_valid  output  1      out_data valid
//   out_ready  input   1      consumer accepts out_data this cycle
//   out_data   output  OUT_W  extended result
//   out_count  output  CNT_W  number of completed output transfers, mod 2^CNT_W
// BEHAVIOUR
//   Clock and reset:
//   - Single clock, synchronous active-high reset.
//   - Reset, sampled at a posedge, clears: out_valid=0, out_data=0, out_count=0, both buffer entries.
//   - in_ready=1 from the first cycle after reset deasserts; inputs presented during reset are dropped.
//   - Reset mid-operation discards buffered results with no output handshake.
//   Extension is combinational on input and registered into the buffer:
//   - 00: {(OUT_W-IN_W){1'b0}, in_imm}
//   - 01: {(OUT_W-IN_W){in_imm[IN_W-1]}, in_imm}
//   - 10: {(OUT_W-IN_W){1'b1}, in_imm}
//   - 11: sign-extend, then << SHIFT_AMT; bits shifted past OUT_W-1 are lost; zeros fill the LSBs.
//   - IN_W==OUT_W: modes 00/01/10 pass through unchanged; 11 is a plain shift.
//   Handshake:
//   - Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
//   - in_valid/in_imm/in_mode hold until the input transfer.
//   - out_data stays stable while out_valid=1 and out_ready=0.
//   - Latency: input accepted at edge N -> out_valid=1 after edge N; earliest output transfer is cycle N+1.
//   Buffer FSM (main = output register, skid = overflow entry):
//   - EMPTY: out_valid=0, in_ready=1. Input xfer -> ONE.
//   - ONE: out_valid=1, in_ready=1.
//     - in & out xfer: main <= new value, stay ONE.
//     - in xfer only: skid <= new value -> TWO.
//     - out xfer only -> EMPTY.
//   - TWO: out_valid=1, in_ready=0.
//     - out xfer: main <= skid -> ONE.
//   - in_ready is a registered output (true iff state != TWO); no combinational path from out_ready.
//   - Order is strict FIFO; no loss or duplication under any in/out pattern.
//   out_count:
//   - +1 on each output transfer; wraps from 2^CNT_W-1 to 0.
//   - Counts completed outputs only; never counts during reset.
//   Out-of-range parameters are an elaboration error ($error in an initial check).
// TESTING
//   1. Defaults, mode 01, in_imm=7'b1000000 -> out_data=20'hFFFC0 one cycle later; out_count=1.
//   2. Mode 00, in_imm=7'b1111111 -> 20'h0007F.
//      Mode 10, in_imm=7'b0000001 -> 20'hFFF81.
//   3. Mode 11, in_imm=7'b1010101 -> 20'hFFFAA.
//      Mode 11, in_imm=7'b0011111 -> 20'h0003E.
//   4. Backpressure: out_ready=0, stream 3 inputs (0x01,0x40,0x7F, mode 01).
//      in_ready drops after 2nd accept; release out_ready.
//      Outputs in order 20'h00001, 20'hFFFC0, 20'hFFFFF; no loss.
//   5. Full throughput: in_valid=out_ready=1 for 300 cycles.
//      One output per cycle; out_count wraps 255->0 (CNT_W=8).
//   6. Assert reset while state=TWO -> next cycle out_valid=0, out_count=0, in_ready=1; no stale data emitted.
//      Re-run with IN_W=12, OUT_W=32, SHIFT_AMT=2: 12'h800 mode 11 -> 32'hFFFFE000.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: widens an immediate field (zero/sign/ones-fill/sign+shift) behind a
// valid/ready interface whose 2-entry skid buffer keeps one transfer per cycle under backpressure.
module imm_extend_pipe #(
    parameter int IN_W      = 7,
    parameter int OUT_W     = 20,
    parameter int SHIFT_AMT = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);
    if (IN_W < 1 || IN_W > OUT_W || OUT_W > 32 || SHIFT_AMT < 0 || SHIFT_AMT > OUT_W - 1 || CNT_W < 1) begin : g_bad_param
        $error("imm_extend_pipe: parameter out of range");
    end

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] main_q, main_d, skid_q, skid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0] zx, sx, ext;
    logic             in_xfer, out_xfer;

    // Size casts keep the IN_W==OUT_W case legal: no zero-width replications.
    assign zx  = OUT_W'(in_imm);
    assign sx  = OUT_W'($signed(in_imm));
    assign ext = in_mode == 2'b00 ? zx :
                 in_mode == 2'b01 ? sx :
                 in_mode == 2'b10 ? zx | ~OUT_W'({IN_W{1'b1}}) :
                 sx << SHIFT_AMT;

    assign in_ready  = state_q != TWO;
    assign out_valid = state_q != EMPTY;
    assign out_data  = main_q;
    assign out_count = count_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q + CNT_W'(out_xfer);
        case (state_q)
            EMPTY: if (in_xfer) begin
                main_d  = ext;
                state_d = ONE;
            end
            ONE: if (in_xfer && out_xfer) begin
                main_d = ext;
            end else if (in_xfer) begin
                skid_d  = ext;
                state_d = TWO;
            end else if (out_xfer) begin
                state_d = EMPTY;
            end
            TWO: if (out_xfer) begin
                main_d  = skid_q;
                state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end
endmodule
